sdft_bin_engine: RTL



---
 rtl/sdft_bin_engine_if.sv | 30 +++
 rtl/sdft_bin_engine.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sdft_bin_engine_if.sv
// Sample stream, twiddle ROM and bin read-port signals of the sliding-DFT bin engine.
// The engine takes the slave side; the sample source / ROM / reader takes the master side.
interface sdft_bin_engine_if #(
   parameter int ADDR_WIDTH = 7,
   parameter int DATA_WIDTH = 8,
   parameter int TW_WIDTH   = 8,
   parameter int BIN_WIDTH  = 16
);
   logic signed [DATA_WIDTH-1:0] sample_in;
   logic                         sample_valid;
   logic                         ready;
   logic        [ADDR_WIDTH-1:0] twiddle_addr;
   logic signed [TW_WIDTH-1:0]   twiddle_real;
   logic signed [TW_WIDTH-1:0]   twiddle_imag;
   logic        [ADDR_WIDTH-1:0] bin_addr;
   logic signed [BIN_WIDTH-1:0]  bin_real;
   logic signed [BIN_WIDTH-1:0]  bin_imag;
   logic                         frame_done;
   logic                         overrun;

   modport master (
      output sample_in, sample_valid, twiddle_real, twiddle_imag, bin_addr,
      input  ready, twiddle_addr, bin_real, bin_imag, frame_done, overrun
   );

   modport slave (
      input  sample_in, sample_valid, twiddle_real, twiddle_imag, bin_addr,
      output ready, twiddle_addr, bin_real, bin_imag, frame_done, overrun
   );
endinterface

// File: rtl/sdft_bin_engine.sv
// Sliding-DFT update engine: per accepted sample, X_k <= (X_k + x[n] - x[n-N]) * W_k for all N bins.
// Optional macro SDFT_SATURATE_EN clamps bin results instead of two's-complement wrapping.
module sdft_bin_engine #(
   parameter int ADDR_WIDTH = 7,
   parameter int DATA_WIDTH = 8,
   parameter int TW_WIDTH   = 8,
   parameter int BIN_WIDTH  = 16
) (
   input logic              clk,
   input logic              reset,
   sdft_bin_engine_if.slave bus
);
   localparam int N       = 1 << ADDR_WIDTH;
   localparam int DELTA_W = DATA_WIDTH + 1;
   localparam int SUM_W   = BIN_WIDTH + 1;
   localparam int PROD_W  = SUM_W + TW_WIDTH + 1;
   localparam int SHIFT   = TW_WIDTH - 2;
   localparam logic [ADDR_WIDTH-1:0] K_LAST = ADDR_WIDTH'(N - 1);

   typedef enum logic [2:0] {IDLE, DELTA, RUN, DRAIN, DONE} state_t;

   state_t                       state;
   logic        [ADDR_WIDTH-1:0] wptr;
   logic        [ADDR_WIDTH-1:0] k;
   logic                         drain_cnt;
   logic                         ready;
   logic                         frame_done;
   logic                         overrun;
   logic                         accept;

   logic signed [DATA_WIDTH-1:0] sample_hold;
   logic signed [DATA_WIDTH-1:0] old_hold;
   logic signed [DELTA_W-1:0]    delta;
   logic signed [DATA_WIDTH-1:0] dline   [N];
   logic signed [BIN_WIDTH-1:0]  bins_re [N];
   logic signed [BIN_WIDTH-1:0]  bins_im [N];

   logic                         vld_p1, vld_p2;
   logic        [ADDR_WIDTH-1:0] addr_p1, addr_p2;
   logic signed [BIN_WIDTH-1:0]  bin_re_p1, bin_im_p1;
   logic signed [SUM_W-1:0]      sum_r_p2, sum_i_p2;
   logic signed [TW_WIDTH-1:0]   twr_p2, twi_p2;
   logic signed [PROD_W-1:0]     acc_re, acc_im;
   logic signed [BIN_WIDTH-1:0]  new_re, new_im;
   logic signed [BIN_WIDTH-1:0]  bin_real_q, bin_imag_q;

   // Narrow a rescaled product to bin width: clamp or wrap depending on the build.
   function automatic logic signed [BIN_WIDTH-1:0] fit_bin(input logic signed [PROD_W-1:0] v);
`ifdef SDFT_SATURATE_EN
      logic [PROD_W-BIN_WIDTH:0] hi;
      hi = v[PROD_W-1:BIN_WIDTH-1];
      if (!v[PROD_W-1] && (|hi)) return {1'b0, {(BIN_WIDTH-1){1'b1}}};
      if (v[PROD_W-1] && !(&hi)) return {1'b1, {(BIN_WIDTH-1){1'b0}}};
      return v[BIN_WIDTH-1:0];
`else
      logic unused_hi;
      unused_hi = ^v[PROD_W-1:BIN_WIDTH];
      return v[BIN_WIDTH-1:0];
`endif
   endfunction

   assign accept = bus.sample_valid && ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         ready      <= 1'b1;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
         wptr       <= '0;
         k          <= '0;
         drain_cnt  <= 1'b0;
         vld_p1     <= 1'b0;
         vld_p2     <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         vld_p1     <= (state == RUN);
         vld_p2     <= vld_p1;
         if (bus.sample_valid && !ready) overrun <= 1'b1;
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  ready <= 1'b0;
                  state <= DELTA;
               end else begin
                  state <= IDLE;
               end
            end
            DELTA: begin
               wptr  <= wptr + ADDR_WIDTH'(1);
               k     <= '0;
               state <= RUN;
            end
            RUN: begin
               k <= k + ADDR_WIDTH'(1);
               if (k == K_LAST) begin
                  drain_cnt <= 1'b0;
                  state     <= DRAIN;
               end
            end
            DRAIN: begin
               drain_cnt <= 1'b1;
               if (drain_cnt) begin
                  ready      <= 1'b1;
                  frame_done <= 1'b1;
                  state      <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The delay line slot being overwritten holds x[n-N] until DELTA commits the new sample.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) dline[i] <= '0;
      end else if (state == DELTA) begin
         dline[wptr] <= sample_hold;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         sample_hold <= bus.sample_in;
         old_hold    <= dline[wptr];
      end
      if (state == DELTA) delta <= DELTA_W'(sample_hold) - DELTA_W'(old_hold);
   end

   // Stage 0 -> 1: bin k read in step with the ROM fetch of twiddle k
   always_ff @(posedge clk) begin
      addr_p1   <= k;
      bin_re_p1 <= bins_re[k];
      bin_im_p1 <= bins_im[k];
   end

   // Stage 1 -> 2: twiddle arrives; fold delta into the real part
   always_ff @(posedge clk) begin
      addr_p2  <= addr_p1;
      sum_r_p2 <= SUM_W'(bin_re_p1) + SUM_W'(delta);
      sum_i_p2 <= SUM_W'(bin_im_p1);
      twr_p2   <= bus.twiddle_real;
      twi_p2   <= bus.twiddle_imag;
   end

   // Stage 2: full-precision complex multiply, floor rescale, narrow
   always_comb begin
      acc_re = PROD_W'(sum_r_p2) * PROD_W'(twr_p2) - PROD_W'(sum_i_p2) * PROD_W'(twi_p2);
      acc_im = PROD_W'(sum_r_p2) * PROD_W'(twi_p2) + PROD_W'(sum_i_p2) * PROD_W'(twr_p2);
      new_re = fit_bin(acc_re >>> SHIFT);
      new_im = fit_bin(acc_im >>> SHIFT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            bins_re[i] <= '0;
            bins_im[i] <= '0;
         end
         bin_real_q <= '0;
         bin_imag_q <= '0;
      end else begin
         if (vld_p2) begin
            bins_re[addr_p2] <= new_re;
            bins_im[addr_p2] <= new_im;
         end
         bin_real_q <= bins_re[bus.bin_addr];
         bin_imag_q <= bins_im[bus.bin_addr];
      end
   end

   assign bus.ready        = ready;
   assign bus.twiddle_addr = k;
   assign bus.bin_real     = bin_real_q;
   assign bus.bin_imag     = bin_imag_q;
   assign bus.frame_done   = frame_done;
   assign bus.overrun      = overrun;
endmodule
